// File: rtl/mem_cache_controller_if.sv
// Pipeline-side and SRAM-side signals of the MEM-stage data cache.
// The controller takes the slave view; the pipeline/SRAM environment takes the master view.
interface mem_cache_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/mem_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit in one cycle; misses fetch a 64-bit line, stores go straight to SRAM.
module mem_cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned SET_BITS  = 6,
    parameter int unsigned TAG_BITS  = 9
) (
    input logic                   clk,
    input logic                   rst,
    mem_cache_controller_if.slave bus
);
    localparam int unsigned SETS = 1 << SET_BITS;

    typedef enum logic [1:0] {StIdle, StReadMiss, StWrite} state_e;

    state_e state_q, state_d;

    logic [1:0]          valid_q [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS][2];
    logic [63:0]         data_q  [SETS][2];
    logic [SETS-1:0]     lru_q;

    logic [31:0]         eff;
    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                word_sel;
    logic                hit0, hit1, hit, hit_way, victim;
    logic                fill_en, touch_en, inval_en;
    logic [63:0]         line_sel;

    assign eff      = bus.address - BASE_ADDR;
    assign word_sel = eff[2];
    assign idx      = eff[3 +: SET_BITS];
    assign tag      = eff[SET_BITS + 3 +: TAG_BITS];

    assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
    assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;
    // Invalid ways are filled before evicting the least-recently-used one.
    assign victim  = !valid_q[idx][0] ? 1'b0 :
                     !valid_q[idx][1] ? 1'b1 : ~lru_q[idx];

    always_comb begin
        state_d          = state_q;
        bus.ready        = 1'b0;
        bus.sram_r_en    = 1'b0;
        bus.sram_w_en    = 1'b0;
        bus.sram_address = eff;
        bus.sram_wdata   = bus.wdata;
        fill_en          = 1'b0;
        touch_en         = 1'b0;
        inval_en         = 1'b0;
        line_sel         = data_q[idx][hit_way];

        unique case (state_q)
            StIdle: begin
                if (bus.MEM_W_EN) begin
                    state_d  = StWrite;
                    inval_en = hit;
                end else if (bus.MEM_R_EN) begin
                    if (hit) begin
                        bus.ready = 1'b1;
                        touch_en  = 1'b1;
                    end else begin
                        state_d = StReadMiss;
                    end
                end else begin
                    bus.ready = 1'b1;
                end
            end
            StReadMiss: begin
                bus.sram_r_en    = 1'b1;
                bus.sram_address = {eff[31:3], 3'b000};
                line_sel         = bus.sram_rdata;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    fill_en   = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrite: begin
                bus.sram_w_en = 1'b1;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        bus.rdata = word_sel ? line_sel[63:32] : line_sel[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            lru_q   <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 2'b00;
            end
        end else begin
            state_q <= state_d;
            if (touch_en) begin
                lru_q[idx] <= hit_way;
            end
            if (fill_en) begin
                valid_q[idx][victim] <= 1'b1;
                tag_q[idx][victim]   <= tag;
                data_q[idx][victim]  <= bus.sram_rdata;
                lru_q[idx]           <= victim;
            end
            if (inval_en) begin
                valid_q[idx][hit_way] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_cache_controller.sv
// Table-driven bench for mem_cache_controller with a load-data scoreboard and an SRAM model.
module tb_mem_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_cache_controller_if bus ();

    mem_cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [63:0] line;
        logic        miss;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb [$];
    vec_t        vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [63:0] line,
                                input logic miss, input logic [31:0] exp);
        vec_t v;
        v.w = w; v.r = r; v.addr = addr; v.wdata = wdata; v.lat = lat;
        v.line = line; v.miss = miss; v.exp = exp;
        return v;
    endfunction

    // Starts just after a rising edge; returns just after the edge that completes the request.
    task automatic run_vec(input int n, input vec_t v);
        int          r_cnt = 0, w_cnt = 0, bad = 0, cyc = 0;
        bit          done = 0;
        logic [31:0] eff = v.addr - 32'd1024;
        logic [31:0] got;
        bus.address    = v.addr;
        bus.wdata      = v.wdata;
        bus.MEM_W_EN   = v.w;
        bus.MEM_R_EN   = v.r;
        bus.sram_rdata = v.line;
        if (!v.w) sb.push_back(v.exp);
        while (!done && cyc < 64) begin
            if (bus.sram_r_en) begin
                r_cnt++;
                if (bus.sram_address !== {eff[31:3], 3'b000}) bad++;
            end
            if (bus.sram_w_en) begin
                w_cnt++;
                if (bus.sram_address !== eff || bus.sram_wdata !== v.wdata) bad++;
            end
            if (bus.sram_r_en && bus.sram_w_en) bad++;
            bus.sram_ready = (bus.sram_r_en || bus.sram_w_en) && (r_cnt + w_cnt > v.lat);
            #2;
            if (bus.ready) begin
                done = 1;
                if (!v.w) begin
                    got = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                    check($sformatf("v%0d rdata", n), bus.rdata, got);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.sram_ready = 1'b0;
        check($sformatf("v%0d done", n), done, 1'b1);
        check($sformatf("v%0d sram_r_cycles", n), r_cnt, (!v.w && v.miss) ? v.lat + 1 : 0);
        check($sformatf("v%0d sram_w_cycles", n), w_cnt, v.w ? v.lat + 1 : 0);
        check($sformatf("v%0d sram_bus", n), bad, 0);
    endtask

    initial begin
        int bad;
        vecs[0]  = mk(0, 1, 32'h400, 0, 4, 64'h1111_2222_3333_4444, 1, 32'h3333_4444);
        vecs[1]  = mk(0, 1, 32'h404, 0, 0, 64'h0, 0, 32'h1111_2222);
        vecs[2]  = mk(0, 1, 32'h800, 0, 2, 64'hAAAA_0001_BBBB_0002, 1, 32'hBBBB_0002);
        vecs[3]  = mk(0, 1, 32'h400, 0, 0, 64'h0, 0, 32'h3333_4444);
        vecs[4]  = mk(0, 1, 32'hC00, 0, 1, 64'hCCCC_0003_DDDD_0004, 1, 32'hDDDD_0004);
        vecs[5]  = mk(0, 1, 32'h404, 0, 0, 64'h0, 0, 32'h1111_2222);
        vecs[6]  = mk(0, 1, 32'hC04, 0, 0, 64'h0, 0, 32'hCCCC_0003);
        vecs[7]  = mk(0, 1, 32'h800, 0, 3, 64'hAAAA_0001_BBBB_0002, 1, 32'hBBBB_0002);
        vecs[8]  = mk(1, 0, 32'hC00, 32'hDEAD_BEEF, 2, 64'h0, 1, 32'h0);
        vecs[9]  = mk(0, 1, 32'hC04, 0, 1, 64'hCCCC_0003_DDDD_0004, 1, 32'hCCCC_0003);
        vecs[10] = mk(1, 0, 32'h500, 32'h1234_5678, 0, 64'h0, 1, 32'h0);
        vecs[11] = mk(0, 1, 32'h500, 0, 0, 64'h5555_6666_7777_8888, 1, 32'h7777_8888);
        vecs[12] = mk(0, 1, 32'h804, 0, 0, 64'h0, 0, 32'hAAAA_0001);
        vecs[13] = mk(0, 1, 32'hC00, 0, 0, 64'h0, 0, 32'hDDDD_0004);
        vecs[14] = mk(0, 1, 32'h400, 0, 1, 64'h1111_2222_3333_4444, 1, 32'h3333_4444);
        vecs[15] = mk(1, 0, 32'h400, 32'hDEAD_BEEF, 3, 64'h0, 1, 32'h0);
        vecs[16] = mk(0, 1, 32'h400, 0, 2, 64'h9999_0000_AAAA_BBBB, 1, 32'hAAAA_BBBB);
        vecs[17] = mk(1, 1, 32'h400, 32'h0BAD_F00D, 1, 64'h0, 1, 32'h0);
        vecs[18] = mk(0, 1, 32'h404, 0, 0, 64'h1234_5678_9ABC_DEF0, 1, 32'h1234_5678);
        vecs[19] = mk(0, 1, 32'h404, 0, 0, 64'h0, 0, 32'h1234_5678);

        bus.address = '0; bus.wdata = '0; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
        bus.sram_rdata = '0; bus.sram_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("reset ready", bus.ready, 1'b1);
        check("reset sram_en", {bus.sram_r_en, bus.sram_w_en}, 2'b00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

        // Idle: no requests for 10 cycles.
        bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!bus.ready || bus.sram_r_en || bus.sram_w_en) bad++;
            @(posedge clk);
            #1;
        end
        check("idle cycles", bad, 0);

        // Reset in the middle of a read miss, then a stray sram_ready.
        bus.address = 32'h800; bus.MEM_R_EN = 1'b1; bus.sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        check("midmiss r_en", bus.sram_r_en, 1'b1);
        check("midmiss ready", bus.ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.MEM_R_EN = 1'b0;
        #1;
        check("post-reset sram_en", {bus.sram_r_en, bus.sram_w_en}, 2'b00);
        check("post-reset ready", bus.ready, 1'b1);
        bus.sram_ready = 1'b1;
        @(posedge clk);
        #1 bus.sram_ready = 1'b0;
        #1;
        check("late sram_ready en", {bus.sram_r_en, bus.sram_w_en}, 2'b00);
        check("late sram_ready ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        run_vec(20, mk(0, 1, 32'h404, 0, 1, 64'h4444_3333_2222_1111, 1, 32'h4444_3333));
        run_vec(21, mk(0, 1, 32'h400, 0, 0, 64'h0, 0, 32'h2222_1111));

        check("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_cache_controller.md
Name: mem_cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache controller for the MEM stage of the ARM pipeline.
- Consumes the memory request held in the EXE/MEM pipeline register and returns load data toward the MEM/WB register.
- Drives a 64-bit-line SRAM controller through a request/ready handshake.
- Its ready output is inverted upstream to form the freeze input of the EXE and MEM stage registers.

Parameters:
BASE_ADDR, 32'd1024, byte address subtracted from every request before decode
SET_BITS, 6, index width; sets = 2**SET_BITS = 64
TAG_BITS, 9, tag width; effective address bits [SET_BITS+11:SET_BITS+3]

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
address  input  32  byte address of load/store (EXE-stage ALU result)
wdata  input  32  store data (Val_Rm)
MEM_R_EN  input  1  load request
MEM_W_EN  input  1  store request
rdata  output  32  load data; valid when ready=1 and MEM_R_EN=1
ready  output  1  request complete this cycle; pipeline freeze = ~ready
sram_address  output  32  effective address to SRAM controller
sram_wdata  output  32  store data to SRAM controller
sram_r_en  output  1  line-read request
sram_w_en  output  1  word-write request
sram_rdata  input  64  returned line: [31:0] word 0, [63:32] word 1
sram_ready  input  1  SRAM op completes this cycle (single-cycle pulse)

Behaviour:
- Address decode: eff = address - BASE_ADDR.
  - eff[1:0] ignored.
  - eff[2] = word select.
  - eff[8:3] = index.
  - eff[17:9] = tag.
  - Higher bits ignored.
- Storage per set: 2 ways × {valid, tag[8:0], data[63:0]}, plus one lru bit.
  - lru holds the most-recently-used way.
  - Victim selection order: invalid way0 first, else invalid way1, else ~lru.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE:
  - No request: ready=1, SRAM enables 0.
  - MEM_W_EN=1 (priority over MEM_R_EN): ready=0; next state WRITE. On a tag hit, the matching way's valid bit is cleared at this edge.
  - MEM_R_EN=1 with hit: ready=1 combinationally the same cycle; rdata = selected word of the hit way; lru ← hit way at the edge; SRAM untouched.
  - MEM_R_EN=1 with miss: ready=0; next state READ_MISS.
- READ_MISS:
  - sram_r_en=1, sram_address = {eff[31:3],3'b000}, held until sram_ready.
  - Cycle in which sram_ready=1:
    - rdata = word eff[2] of sram_rdata (combinational bypass); ready=1.
    - Victim way filled with data, tag, valid=1; lru ← filled way.
    - Next state IDLE.
- WRITE:
  - sram_w_en=1, sram_address = eff, sram_wdata = wdata, held until sram_ready.
  - Cycle in which sram_ready=1: ready=1; next state IDLE.
  - Cache contents are never written with store data.
- Upstream keeps address, wdata and enables stable while ready=0. After a ready=1 cycle, a new request may appear the next cycle.
- ready and rdata are combinational. rdata is don't-care when not qualified.
- sram_r_en and sram_w_en are decoded from the registered state only; never both 1.
- Reset (rst=0 at an edge), from any state including mid-miss or mid-write:
  - State ← IDLE; all 128 valid bits and 64 lru bits ← 0.
  - From the next cycle, sram_r_en=sram_w_en=0 and ready follows the IDLE rules.
  - An outstanding SRAM op is abandoned; a late sram_ready in IDLE is ignored.
- Read of a set whose lru points to a just-invalidated way still follows the victim order above (invalid way first).

Test Plan:
- Cold read: rst pulse, then load 0x400. SRAM answers sram_ready with 64'h1111_2222_3333_4444 after 4 cycles -> sram_r_en=1 with sram_address=0 for 4 cycles; ready=0 for 4 cycles; ready=1 with rdata=0x33334444 on the sram_ready cycle. Following load 0x404 -> same-cycle ready=1, rdata=0x11112222, sram_r_en stays 0.
- LRU replacement: fill 0x400 (tag 0, way0), then 0x800 (tag 2, way1), then hit 0x400, then load 0xC00 (tag 4, same set 0) -> 0xC00 replaces 0x800's way. After that, 0x400 hits and 0x800 misses (sram_address=0x400).
- Write-through invalidate: with 0x400 cached, store 0xDEADBEEF to 0x400 -> sram_w_en=1, sram_address=0, sram_wdata=0xDEADBEEF until sram_ready, ready=1 that cycle. Next load 0x400 misses.
- Write miss: store to uncached 0x500 -> SRAM write only. Subsequent load 0x500 misses (no allocate).
- Reset mid-miss: assert rst=0 for one edge during READ_MISS -> next cycle sram_r_en=0 and ready=1 with no request. Sram_ready arriving afterwards has no effect. Previously cached 0x400 now misses.
- Idle and conflict: no enables for 10 cycles -> ready=1, SRAM enables 0. MEM_R_EN=MEM_W_EN=1 on address 0x400 -> handled as a write (sram_w_en=1, sram_r_en=0).
